// File: rtl/weight_bram_scheduler.sv
// Arbitrates the weight BRAM between the AXI-Stream weight writer and the compute-side
// weight fetch; reads take priority and never share port A with a write in the same cycle.
module weight_bram_scheduler #(
  parameter int unsigned BRAM_ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned READ_LATENCY       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // AXI-Stream weight writer
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  input  logic                          wr_addr_reset,
  output logic                          wr_full,
  // Control unit weight fetch
  input  logic                          rd_req,
  input  logic                          address_reset,
  input  logic                          bram_control_add1,
  input  logic                          bram_control_add2,
  input  logic                          bram_port_sel,
  // BRAM port A (read/write)
  output logic                          bram_a_en,
  output logic                          bram_a_we,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_a_addr,
  output logic [DATA_WIDTH-1:0]         bram_a_din,
  input  logic [DATA_WIDTH-1:0]         bram_a_dout,
  // BRAM port B (read only)
  output logic                          bram_b_en,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_b_addr,
  input  logic [DATA_WIDTH-1:0]         bram_b_dout,
  // Fetched weight
  output logic [DATA_WIDTH-1:0]         weight_data,
  output logic                          weight_from_bram_valid,
  output logic                          busy
);

  localparam int unsigned AW   = BRAM_ADDRESS_WIDTH;
  localparam int unsigned CntW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdIssue,
    StRdWait,
    StRdDone
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         wr_addr_q;
  logic                  wr_full_q;
  logic [AW-1:0]         rd_addr_q;
  logic [CntW-1:0]       wait_cnt_q;
  logic                  port_sel_q;
  logic [DATA_WIDTH-1:0] weight_data_q;

  logic beat;
  logic wait_last;
  logic wr_at_top;
  logic [1:0] rd_step;

  assign wr_at_top = (wr_addr_q == {AW{1'b1}});
  assign wait_last = (wait_cnt_q == CntW'(READ_LATENCY - 1));
  assign rd_step   = {bram_control_add2, bram_control_add1};

  always_comb begin
    state_d                = state_q;
    beat                   = 1'b0;
    s_axis_tready          = 1'b0;
    bram_a_en              = 1'b0;
    bram_a_we              = 1'b0;
    bram_a_addr            = '0;
    bram_a_din             = '0;
    bram_b_en              = 1'b0;
    bram_b_addr            = '0;
    weight_from_bram_valid = 1'b0;
    busy                   = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          state_d = StRdIssue;
        end else if (s_axis_tvalid && !wr_full_q) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        s_axis_tready = ~wr_full_q;
        beat          = s_axis_tvalid & ~wr_full_q;
        if (beat) begin
          bram_a_en   = 1'b1;
          bram_a_we   = 1'b1;
          bram_a_addr = wr_addr_q;
          bram_a_din  = s_axis_tdata;
          // Hitting the top address truncates the burst; later beats stall.
          if (s_axis_tlast || wr_at_top) begin
            state_d = StIdle;
          end
        end
      end
      StRdIssue: begin
        if (bram_port_sel) begin
          bram_b_en   = 1'b1;
          bram_b_addr = rd_addr_q;
        end else begin
          bram_a_en   = 1'b1;
          bram_a_addr = rd_addr_q;
        end
        state_d = StRdWait;
      end
      StRdWait: begin
        if (wait_last) begin
          state_d = StRdDone;
        end
      end
      StRdDone: begin
        weight_from_bram_valid = 1'b1;
        state_d                = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_addr_q     <= '0;
      wr_full_q     <= 1'b0;
      rd_addr_q     <= '0;
      wait_cnt_q    <= '0;
      port_sel_q    <= 1'b0;
      weight_data_q <= '0;
    end else begin
      state_q <= state_d;

      // A coincident beat still writes the old address; the reset wins the update.
      if (wr_addr_reset) begin
        wr_addr_q <= '0;
        wr_full_q <= 1'b0;
      end else if (beat) begin
        wr_addr_q <= wr_addr_q + 1'b1;
        if (wr_at_top) begin
          wr_full_q <= 1'b1;
        end
      end

      if (address_reset) begin
        rd_addr_q <= '0;
      end else begin
        rd_addr_q <= rd_addr_q + AW'(rd_step);
      end

      if (state_q == StRdIssue) begin
        wait_cnt_q <= '0;
        port_sel_q <= bram_port_sel;
      end else if (state_q == StRdWait) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
        if (wait_last) begin
          weight_data_q <= port_sel_q ? bram_b_dout : bram_a_dout;
        end
      end
    end
  end

  assign wr_full     = wr_full_q;
  assign weight_data = weight_data_q;

endmodule
